// File: rtl/serial_addsub_if.sv
// Start/done handshake and operand/result bundle for the bit-serial adder/subtractor.
// The requester drives start, a, b and sub. The adder returns the status, the result and the flags.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, sub,
    input  ready, busy, done, sum, co, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output ready, busy, done, sum, co, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell and a carry flop,
// one bit per clock LSB first, with a start/done handshake and carry/overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             co_q;
  logic             ovf_q;
  logic             s_bit;
  logic             carry_next;

  // The single full-adder cell.
  always_comb begin
    s_bit      = sa[0] ^ sb[0] ^ carry;
    carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values. The shift, the carry update and the flag capture then happen in parallel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sum_q <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract works as A + ~B + 1, with the +1 coming in through the initial carry.
            sa    <= bus.a;
            sb    <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sum_q <= (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
          carry <= carry_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // At this point carry still holds the carry into the MSB.
            co_q  <= carry_next;
            ovf_q <= carry ^ carry_next;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.co    = co_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub, checking an 8-bit instance and a 1-bit instance
// against hand-computed sums, flags and handshake timing.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(1)) bus1 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge. Counts negedges from the start drive up to the first done,
  // bounded at 40.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] es, input logic eco, input logic eovf,
                     input string tag);
    int n;
    bus8.a = a; bus8.b = b; bus8.sub = s; bus8.start = 1'b1;
    @(negedge clk);
    n = 1;
    bus8.start = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.sub = ~s;
    check({tag, "_busy"}, bus8.busy, 1'b1);
    check({tag, "_ready"}, bus8.ready, 1'b0);
    while (!bus8.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 9);
    check({tag, "_sum"}, bus8.sum, es);
    check({tag, "_co"}, bus8.co, eco);
    check({tag, "_ovf"}, bus8.ovf, eovf);
    @(negedge clk);
    check({tag, "_done1"}, bus8.done, 1'b0);
    check({tag, "_rdy"}, bus8.ready, 1'b1);
  endtask

  initial begin
    int n;
    int seen;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0;

    #12;
    check("rst_ready", bus8.ready, 1'b1);
    check("rst_busy", bus8.busy, 1'b0);
    check("rst_done", bus8.done, 1'b0);
    check("rst_sum", bus8.sum, 8'h00);
    check("rst_co", bus8.co, 1'b0);
    check("rst_ovf", bus8.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op8(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, "add");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_add");
    op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "borrow");
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "ovf_sub");

    // Start held high: the ops run back to back with a period of WIDTH+2.
    bus8.a = 8'h10; bus8.b = 8'h22; bus8.sub = 1'b0; bus8.start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus8.done && n < 40);
    check("b2b_first", n, 9);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus8.done && n < 40);
    check("b2b_period", n, 10);
    check("b2b_sum", bus8.sum, 8'h32);
    bus8.start = 1'b0;
    @(negedge clk);

    // Start pulses during RUN and DONE must be ignored.
    bus8.a = 8'h21; bus8.b = 8'h13; bus8.sub = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 4;
    while (!bus8.done && n < 40) begin @(negedge clk); n++; end
    check("ign_lat", n, 9);
    check("ign_sum", bus8.sum, 8'h0E);
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (bus8.done) seen++; end
    check("ign_nodone", seen, 0);
    check("ign_hold", bus8.sum, 8'h0E);
    check("ign_ready", bus8.ready, 1'b1);

    // Reset mid-RUN at cnt=4. The preceding op leaves sum=7F, co=1 and ovf=1.
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "pre_rst");
    bus8.a = 8'h55; bus8.b = 8'h0F; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_ready", bus8.ready, 1'b1);
    check("mid_busy", bus8.busy, 1'b0);
    check("mid_sum", bus8.sum, 8'h00);
    check("mid_co", bus8.co, 1'b0);
    check("mid_ovf", bus8.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (bus8.done) seen++; end
    check("mid_nodone", seen, 0);
    op8(8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0, "post_rst");

    // WIDTH=1 corner: 1+1 gives sum 0, a carry out, and an overflow because the carry into the MSB is 0.
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.sub = 1'b0; bus1.start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; bus1.start = 1'b0; end while (!bus1.done && n < 40);
    check("w1_lat", n, 2);
    check("w1_sum", bus1.sum, 1'b0);
    check("w1_co", bus1.co, 1'b1);
    check("w1_ovf", bus1.ovf, 1'b1);
    @(negedge clk);
    check("w1_done1", bus1.done, 1'b0);
    check("w1_ready", bus1.ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
